// File: rtl/druaga_input_pkg.sv
// druaga_input_pkg: shared constants for the Druaga input controller.
//   - PS/2 scan codes recognised by the key decoder
//   - JOY bit indices for the 16-bit joystick words
//   - flag-vector bit indices (18 key flags)
//   - coin pulse FSM state type
package druaga_input_pkg;

  // Scan codes; the four direction keys match with or without the extended prefix
  localparam logic [7:0] SC_UP      = 8'h75;
  localparam logic [7:0] SC_DOWN    = 8'h72;
  localparam logic [7:0] SC_LEFT    = 8'h6B;
  localparam logic [7:0] SC_RIGHT   = 8'h74;
  localparam logic [7:0] SC_TRIG1   = 8'h29;
  localparam logic [7:0] SC_TRIG2   = 8'h14;
  localparam logic [7:0] SC_F1      = 8'h05;
  localparam logic [7:0] SC_F2      = 8'h06;
  localparam logic [7:0] SC_START1  = 8'h16;
  localparam logic [7:0] SC_START2  = 8'h1E;
  localparam logic [7:0] SC_COIN1   = 8'h2E;
  localparam logic [7:0] SC_COIN2   = 8'h36;
  localparam logic [7:0] SC_UP2     = 8'h2D;
  localparam logic [7:0] SC_DOWN2   = 8'h2B;
  localparam logic [7:0] SC_LEFT2   = 8'h23;
  localparam logic [7:0] SC_RIGHT2  = 8'h34;
  localparam logic [7:0] SC_TRIG1_2 = 8'h1C;
  localparam logic [7:0] SC_TRIG2_2 = 8'h1B;

  // JOY word bit positions
  localparam int unsigned JOY_RIGHT  = 0;
  localparam int unsigned JOY_LEFT   = 1;
  localparam int unsigned JOY_DOWN   = 2;
  localparam int unsigned JOY_UP     = 3;
  localparam int unsigned JOY_TRIG1  = 4;
  localparam int unsigned JOY_TRIG2  = 5;
  localparam int unsigned JOY_START1 = 6;
  localparam int unsigned JOY_START2 = 7;
  localparam int unsigned JOY_COIN   = 8;

  // Key flag vector bit positions
  localparam logic [4:0] FL_UP      = 5'd0;
  localparam logic [4:0] FL_DOWN    = 5'd1;
  localparam logic [4:0] FL_LEFT    = 5'd2;
  localparam logic [4:0] FL_RIGHT   = 5'd3;
  localparam logic [4:0] FL_TRIG1   = 5'd4;
  localparam logic [4:0] FL_TRIG2   = 5'd5;
  localparam logic [4:0] FL_F1      = 5'd6;
  localparam logic [4:0] FL_F2      = 5'd7;
  localparam logic [4:0] FL_START1  = 5'd8;
  localparam logic [4:0] FL_START2  = 5'd9;
  localparam logic [4:0] FL_COIN1   = 5'd10;
  localparam logic [4:0] FL_COIN2   = 5'd11;
  localparam logic [4:0] FL_UP2     = 5'd12;
  localparam logic [4:0] FL_DOWN2   = 5'd13;
  localparam logic [4:0] FL_LEFT2   = 5'd14;
  localparam logic [4:0] FL_RIGHT2  = 5'd15;
  localparam logic [4:0] FL_TRIG1_2 = 5'd16;
  localparam logic [4:0] FL_TRIG2_2 = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } coin_state_t;

endpackage

// File: rtl/druaga_key_decode.sv
// druaga_key_decode: PS/2 key event detection and key flag registers.
//   i_clk     : clock (rising edge)
//   i_reset   : synchronous active-high reset
//   i_ps2_key : [10] toggle, [9] pressed, [8] extended, [7:0] scan code
//   o_flags   : 18 key-held flags, indexed by FL_* in druaga_input_pkg
module druaga_key_decode
  import druaga_input_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [10:0] i_ps2_key,
  output logic [17:0] o_flags
);

  logic        r_toggle;
  logic [17:0] r_flags;
  logic        w_event;
  logic        w_hit;
  logic [4:0]  w_idx;
  logic        w_ext;
  logic [7:0]  w_code;

  assign w_ext   = i_ps2_key[8];
  assign w_code  = i_ps2_key[7:0];
  assign w_event = i_ps2_key[10] ^ r_toggle;
  assign o_flags = r_flags;

  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    case (w_code)
      SC_UP:      begin w_hit = 1'b1;   w_idx = FL_UP;      end
      SC_DOWN:    begin w_hit = 1'b1;   w_idx = FL_DOWN;    end
      SC_LEFT:    begin w_hit = 1'b1;   w_idx = FL_LEFT;    end
      SC_RIGHT:   begin w_hit = 1'b1;   w_idx = FL_RIGHT;   end
      SC_TRIG1:   begin w_hit = !w_ext; w_idx = FL_TRIG1;   end
      SC_TRIG2:   begin w_hit = !w_ext; w_idx = FL_TRIG2;   end
      SC_F1:      begin w_hit = !w_ext; w_idx = FL_F1;      end
      SC_F2:      begin w_hit = !w_ext; w_idx = FL_F2;      end
      SC_START1:  begin w_hit = !w_ext; w_idx = FL_START1;  end
      SC_START2:  begin w_hit = !w_ext; w_idx = FL_START2;  end
      SC_COIN1:   begin w_hit = !w_ext; w_idx = FL_COIN1;   end
      SC_COIN2:   begin w_hit = !w_ext; w_idx = FL_COIN2;   end
      SC_UP2:     begin w_hit = !w_ext; w_idx = FL_UP2;     end
      SC_DOWN2:   begin w_hit = !w_ext; w_idx = FL_DOWN2;   end
      SC_LEFT2:   begin w_hit = !w_ext; w_idx = FL_LEFT2;   end
      SC_RIGHT2:  begin w_hit = !w_ext; w_idx = FL_RIGHT2;  end
      SC_TRIG1_2: begin w_hit = !w_ext; w_idx = FL_TRIG1_2; end
      SC_TRIG2_2: begin w_hit = !w_ext; w_idx = FL_TRIG2_2; end
      default:    begin w_hit = 1'b0;   w_idx = '0;         end
    endcase
  end

  // The toggle copy also loads during reset so a stale toggle never fires an event
  always_ff @(posedge i_clk) begin
    r_toggle <= i_ps2_key[10];
    if (i_reset) begin
      r_flags <= '0;
    end else if (w_event && w_hit) begin
      r_flags[w_idx] <= i_ps2_key[9];
    end
  end

endmodule

// File: rtl/druaga_input_ctrl.sv
// druaga_input_ctrl: merges PS/2 keys and two joysticks into the arcade
// input ports, sampled once per frame, with optional coin pulse shaping.
//   MCLK     : clock (rising edge)
//   RESET    : synchronous active-high reset
//   PS2_KEY  : [10] toggle, [9] pressed, [8] extended, [7:0] scan code
//   JOY1/2   : [0] R [1] L [2] D [3] U [4] trig1 [5] trig2 [6] st1 [7] st2 [8] coin
//   CABINET  : 1 = cocktail (player-2 controls not merged into player 1)
//   VBLK     : vertical blank
//   INP0     : P1 {trig2,trig1,left,down,right,up}
//   INP1     : P2, same order
//   INP2     : {coin,start2,start1}
//   CREDQ    : pending coin credits
// Macro DRUAGA_COIN_PULSE_EN: when defined, coin edges queue credits that are
// replayed as fixed-length pulses; otherwise coin is sampled like other bits.
module druaga_input_ctrl
  import druaga_input_pkg::*;
#(
  parameter int COIN_FRAMES = 4,
  parameter int COIN_GAP    = 4
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic [10:0] PS2_KEY,
  input  logic [15:0] JOY1,
  input  logic [15:0] JOY2,
  input  logic        CABINET,
  input  logic        VBLK,
  output logic [5:0]  INP0,
  output logic [5:0]  INP1,
  output logic [2:0]  INP2,
  output logic [1:0]  CREDQ
);

  logic [17:0] w_flags;
  logic [5:0]  w_p1;
  logic [5:0]  w_p2;
  logic        w_start1;
  logic        w_start2;
  logic        w_coin;
  logic        w_vblk_rise;
  logic        w_unused_joy;
  logic        r_vblk;
  logic        r_sample;
  logic [5:0]  r_inp0;
  logic [5:0]  r_inp1;
  logic [1:0]  r_start;

  druaga_key_decode u_key (
    .i_clk     (MCLK),
    .i_reset   (RESET),
    .i_ps2_key (PS2_KEY),
    .o_flags   (w_flags)
  );

  assign w_unused_joy = ^{JOY1[15:9], JOY2[15:9]};

  assign w_p2 = {w_flags[FL_TRIG2_2] | JOY2[JOY_TRIG2],
                 w_flags[FL_TRIG1_2] | JOY2[JOY_TRIG1],
                 w_flags[FL_LEFT2]   | JOY2[JOY_LEFT],
                 w_flags[FL_DOWN2]   | JOY2[JOY_DOWN],
                 w_flags[FL_RIGHT2]  | JOY2[JOY_RIGHT],
                 w_flags[FL_UP2]     | JOY2[JOY_UP]};

  assign w_p1 = {w_flags[FL_TRIG2] | JOY1[JOY_TRIG2],
                 w_flags[FL_TRIG1] | JOY1[JOY_TRIG1],
                 w_flags[FL_LEFT]  | JOY1[JOY_LEFT],
                 w_flags[FL_DOWN]  | JOY1[JOY_DOWN],
                 w_flags[FL_RIGHT] | JOY1[JOY_RIGHT],
                 w_flags[FL_UP]    | JOY1[JOY_UP]} | (CABINET ? 6'b0 : w_p2);

  assign w_start1 = w_flags[FL_F1] | w_flags[FL_START1] | JOY1[JOY_START1] | JOY2[JOY_START1];
  assign w_start2 = w_flags[FL_F2] | w_flags[FL_START2] | JOY1[JOY_START2] | JOY2[JOY_START2];
  assign w_coin   = w_flags[FL_F1] | w_flags[FL_F2] | w_flags[FL_COIN1] | w_flags[FL_COIN2]
                  | JOY1[JOY_COIN] | JOY2[JOY_COIN];

  assign w_vblk_rise = VBLK & ~r_vblk;

  // Sample one cycle after the VBLK rise is seen; outputs read registered flags,
  // so a key event landing on the sample cycle shows up at the following frame.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_vblk   <= 1'b0;
      r_sample <= 1'b0;
      r_inp0   <= '0;
      r_inp1   <= '0;
      r_start  <= '0;
    end else begin
      r_vblk   <= VBLK;
      r_sample <= w_vblk_rise;
      if (r_sample) begin
        r_inp0  <= w_p1;
        r_inp1  <= w_p2;
        r_start <= {w_start2, w_start1};
      end
    end
  end

  assign INP0 = r_inp0;
  assign INP1 = r_inp1;

`ifdef DRUAGA_COIN_PULSE_EN
  localparam int CNT_MAX = (COIN_FRAMES > COIN_GAP) ? COIN_FRAMES : COIN_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  coin_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_credq;
  logic             r_coin_out;
  logic             r_coin_prev;
  logic             w_coin_rise;
  logic             w_dec;

  assign w_coin_rise = w_coin & ~r_coin_prev;
  assign w_dec       = r_sample && (r_state == ST_IDLE) && (r_credq != 2'd0);

  // r_coin_prev keeps tracking through reset so a held coin does not credit on release of reset
  always_ff @(posedge MCLK) begin
    r_coin_prev <= w_coin;
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_credq    <= '0;
      r_coin_out <= 1'b0;
    end else begin
      if (w_coin_rise && !w_dec) begin
        r_credq <= (r_credq == 2'd3) ? 2'd3 : r_credq + 2'd1;
      end else if (!w_coin_rise && w_dec) begin
        r_credq <= r_credq - 2'd1;
      end
      if (r_sample) begin
        case (r_state)
          ST_IDLE: begin
            if (r_credq != 2'd0) begin
              r_state    <= ST_PULSE;
              r_coin_out <= 1'b1;
              r_cnt      <= CNT_W'(COIN_FRAMES - 1);
            end
          end
          ST_PULSE: begin
            if (r_cnt == '0) begin
              r_state    <= ST_GAP;
              r_coin_out <= 1'b0;
              r_cnt      <= CNT_W'(COIN_GAP - 1);
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_GAP: begin
            if (r_cnt == '0) begin
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: begin
            r_state    <= ST_IDLE;
            r_coin_out <= 1'b0;
          end
        endcase
      end
    end
  end

  assign INP2  = {r_coin_out, r_start};
  assign CREDQ = r_credq;
`else
  localparam int UNUSED_CFG = COIN_FRAMES + COIN_GAP;

  logic r_coin_smp;

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_coin_smp <= 1'b0;
    end else if (r_sample) begin
      r_coin_smp <= w_coin;
    end
  end

  assign INP2  = {r_coin_smp, r_start};
  assign CREDQ = 2'd0;
`endif

endmodule

// File: tb/tb_druaga_input_ctrl.sv
// Directed bench for druaga_input_ctrl; coin checks follow whichever
// DRUAGA_COIN_PULSE_EN build is compiled.
module tb_druaga_input_ctrl;

  logic        MCLK = 1'b0;
  logic        RESET;
  logic [10:0] PS2_KEY;
  logic [15:0] JOY1;
  logic [15:0] JOY2;
  logic        CABINET;
  logic        VBLK;
  logic [5:0]  INP0;
  logic [5:0]  INP1;
  logic [2:0]  INP2;
  logic [1:0]  CREDQ;

  int n_checks = 0;
  int n_err    = 0;
  logic tog    = 1'b0;

  druaga_input_ctrl #(.COIN_FRAMES(4), .COIN_GAP(4)) dut (
    .MCLK    (MCLK),
    .RESET   (RESET),
    .PS2_KEY (PS2_KEY),
    .JOY1    (JOY1),
    .JOY2    (JOY2),
    .CABINET (CABINET),
    .VBLK    (VBLK),
    .INP0    (INP0),
    .INP1    (INP1),
    .INP2    (INP2),
    .CREDQ   (CREDQ)
  );

  always #5 MCLK = ~MCLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  // One frame: VBLK rise, detection, sample, then VBLK low
  task automatic frame();
    VBLK = 1'b1;
    repeat (3) tick();
    VBLK = 1'b0;
    repeat (2) tick();
  endtask

  task automatic key(input logic ext, input logic [7:0] code, input logic press);
    tog = ~tog;
    PS2_KEY = {tog, press, ext, code};
    tick();
  endtask

  task automatic tap();
    JOY1[8] = 1'b1;
    tick();
    JOY1[8] = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; PS2_KEY = '0; JOY1 = '0; JOY2 = '0; CABINET = 1'b0; VBLK = 1'b0;
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    check("rst_inp0", 8'(INP0), 8'h00);
    check("rst_inp1", 8'(INP1), 8'h00);
    check("rst_inp2", 8'(INP2), 8'h00);
    check("rst_credq", 8'(CREDQ), 8'h00);

    // Up key: visible only after a frame sample
    key(1'b0, 8'h75, 1'b1);
    check("up_hold", 8'(INP0), 8'h00);
    frame();
    check("up_press", 8'(INP0), 8'h01);
    key(1'b0, 8'h75, 1'b0);
    frame();
    check("up_release", 8'(INP0), 8'h00);

    // Extended prefix ignored for directions
    key(1'b1, 8'h6B, 1'b1);
    frame();
    check("left_ext", 8'(INP0), 8'h08);
    key(1'b1, 8'h6B, 1'b0);

    // Extended trig1 code must not match
    key(1'b1, 8'h29, 1'b1);
    frame();
    check("trig1_ext_ignored", 8'(INP0), 8'h00);
    key(1'b0, 8'h29, 1'b1);
    frame();
    check("trig1", 8'(INP0), 8'h10);
    key(1'b0, 8'h29, 1'b0);

    // P2 up key merges into P1 in upright cabinet
    key(1'b0, 8'h2D, 1'b1);
    frame();
    check("up2_inp1", 8'(INP1), 8'h01);
    check("up2_inp0", 8'(INP0), 8'h01);
    key(1'b0, 8'h2D, 1'b0);

    // Unknown code has no effect
    key(1'b0, 8'h44, 1'b1);
    frame();
    check("unk_inp0", 8'(INP0), 8'h00);
    check("unk_inp1", 8'(INP1), 8'h00);

    // JOY2 trig1 with CABINET 0 then 1
    JOY2[4] = 1'b1;
    frame();
    check("cab0_inp0", 8'(INP0), 8'h10);
    check("cab0_inp1", 8'(INP1), 8'h10);
    CABINET = 1'b1;
    frame();
    check("cab1_inp0", 8'(INP0), 8'h00);
    check("cab1_inp1", 8'(INP1), 8'h10);
    JOY2 = '0; CABINET = 1'b0;

    // Starts: JOY2 start1 and start2 key
    JOY2[6] = 1'b1;
    key(1'b0, 8'h1E, 1'b1);
    frame();
    check("starts", 8'(INP2[1:0]), 8'h03);
    JOY2[6] = 1'b0;
    key(1'b0, 8'h1E, 1'b0);
    frame();
    check("starts_off", 8'(INP2[1:0]), 8'h00);

    // Key event on the sample cycle itself appears one frame later
    VBLK = 1'b1;
    tick();
    tog = ~tog;
    PS2_KEY = {tog, 1'b1, 1'b0, 8'h74};
    tick();
    check("coinc_key_hidden", 8'(INP0), 8'h00);
    tick();
    VBLK = 1'b0;
    repeat (2) tick();
    frame();
    check("coinc_key_next", 8'(INP0), 8'h02);
    key(1'b0, 8'h74, 1'b0);
    frame();

`ifdef DRUAGA_COIN_PULSE_EN
    // Single tap: 4 samples high in PULSE, 4 low in GAP, one more low in IDLE
    tap();
    check("tap_credq", 8'(CREDQ), 8'h01);
    for (int n = 1; n <= 9; n++) begin
      frame();
      check($sformatf("tap_coin_f%0d", n), 8'(INP2[2]), (n <= 4) ? 8'h01 : 8'h00);
      if (n == 1) check("tap_credq_start", 8'(CREDQ), 8'h00);
    end

    // Five taps saturate at 3; three pulses, each followed by GAP + IDLE samples
    repeat (5) tap();
    check("sat_credq", 8'(CREDQ), 8'h03);
    for (int n = 1; n <= 27; n++) begin
      frame();
      check($sformatf("multi_coin_f%0d", n), 8'(INP2[2]),
            ((n >= 1 && n <= 4) || (n >= 10 && n <= 13) || (n >= 19 && n <= 22)) ? 8'h01 : 8'h00);
      check($sformatf("multi_credq_f%0d", n), 8'(CREDQ),
            (n < 10) ? 8'h02 : (n < 19) ? 8'h01 : 8'h00);
    end

    // Coin rise on the same cycle as the pulse-start decrement leaves CREDQ unchanged
    tap();
    tap();
    check("pre_coinc_credq", 8'(CREDQ), 8'h02);
    VBLK = 1'b1;
    tick();
    JOY1[8] = 1'b1;
    tick();
    check("coinc_credq", 8'(CREDQ), 8'h02);
    check("coinc_pulse", 8'(INP2[2]), 8'h01);
    JOY1[8] = 1'b0;
    tick();
    VBLK = 1'b0;
    repeat (2) tick();
`else
    // Coin sampled directly, no credit queue
    JOY1[8] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      frame();
      check($sformatf("raw_coin_f%0d", n), 8'(INP2[2]), 8'h01);
      check($sformatf("raw_credq_f%0d", n), 8'(CREDQ), 8'h00);
    end
    JOY1[8] = 1'b0;
    frame();
    check("raw_coin_off", 8'(INP2[2]), 8'h00);
    key(1'b0, 8'h2E, 1'b1);
    frame();
    check("coin1_key", 8'(INP2[2]), 8'h01);
    key(1'b0, 8'h2E, 1'b0);
`endif

    // Reset with a flipped toggle and a pending press: no event afterwards
    tog = ~tog;
    PS2_KEY = {tog, 1'b1, 1'b0, 8'h75};
    RESET = 1'b1;
    tick();
    check("mid_rst_inp2", 8'(INP2), 8'h00);
    check("mid_rst_credq", 8'(CREDQ), 8'h00);
    RESET = 1'b0;
    frame();
    check("post_rst_inp0", 8'(INP0), 8'h00);
    check("post_rst_inp2", 8'(INP2), 8'h00);
    check("post_rst_credq", 8'(CREDQ), 8'h00);
    frame();
    check("post_rst_idle", 8'(INP2), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
